// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback port arbiter.
// Holds the queued LU result entry type and register-file constants.
// No logic; imported by the arbiter and its result FIFO.
package wb_pkg;

   localparam int XLEN = 32;
   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO of wb_entry_t holding long-latency unit results.
// Latency: an entry pushed at an edge is visible at the head the next cycle.
// Backpressure: push is ignored while full, pop is ignored while empty.
module wb_result_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      i_clk,
   input  logic      i_rst,
   input  logic      i_push,
   input  wb_entry_t i_push_dat,
   input  logic      i_pop,
   output wb_entry_t o_head,
   output logic      o_full,
   output logic      o_empty
);

   localparam int AW = $clog2(DEPTH);

   wb_entry_t       r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [AW:0]     r_count;

   logic            w_do_push;
   logic            w_do_pop;

   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_head    = r_mem[r_rd_ptr];
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;

   // Storage array: written at the tail, no reset needed since count guards reads.
   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_push_dat;
      end
   end

   // Wrapping pointers plus an occupancy count that tells full from empty.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_do_push && w_do_pop) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Owns the register-file write port: pipeline WB slot first, queued LU results fill idle slots.
// Latency: write port is combinational; LU results land the cycle after acceptance (0 with WB_LU_BYPASS_EN).
// Backpressure: lu_ready drops when the queue is full; stall_req asks for a bubble when the queue starves.
module wb_port_arbiter
   import wb_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_pipe_valid,
   input  logic            i_pipe_regWrite,
   input  logic            i_pipe_is_memRead,
   input  logic            i_pipe_is_memWrite,
   input  logic [4:0]      i_pipe_rd,
   input  logic [XLEN-1:0] i_pipe_alu_data,
   input  logic [XLEN-1:0] i_pipe_mem_data,
   input  logic            i_lu_valid,
   input  logic [4:0]      i_lu_rd,
   input  logic [XLEN-1:0] i_lu_data,
   output logic            o_lu_ready,
   output logic            o_rf_we,
   output logic [4:0]      o_rf_rd,
   output logic [XLEN-1:0] o_rf_wdata,
   output logic            o_stall_req
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);

   logic            w_pipe_wr;
   logic [XLEN-1:0] w_pipe_dat;
   logic            w_lu_acc;
   logic            w_bypass;
   logic            w_push;
   logic            w_pop;
   logic            w_fifo_full;
   logic            w_fifo_empty;
   wb_entry_t       w_push_dat;
   wb_entry_t       w_head;
   logic [CW-1:0]   w_cnt_nxt;

   logic [CW-1:0]   r_starve_cnt;
   logic            r_stall;

   assign w_pipe_wr = i_pipe_valid & i_pipe_regWrite & ~i_pipe_is_memWrite
                    & (i_pipe_rd != REG_ZERO);

   // Nothing is accepted while reset is held, so reset cleanly drops in-flight LU results.
   assign o_lu_ready = ~i_rst & ~w_fifo_full;
   assign w_lu_acc   = i_lu_valid & o_lu_ready;

`ifdef WB_LU_BYPASS_EN
   // An LU result with nothing ahead of it and an idle slot goes straight to the port.
   assign w_bypass = w_lu_acc & w_fifo_empty & ~w_pipe_wr & (i_lu_rd != REG_ZERO);
`else
   assign w_bypass = 1'b0;
`endif

   // Results for x0 are accepted but never stored, so they are never written.
   assign w_push          = w_lu_acc & (i_lu_rd != REG_ZERO) & ~w_bypass;
   assign w_pop           = ~i_rst & ~w_pipe_wr & ~w_fifo_empty;
   assign w_push_dat.rd   = i_lu_rd;
   assign w_push_dat.data = i_lu_data;
   assign o_stall_req     = r_stall;

   wb_result_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_push     (w_push),
      .i_push_dat (w_push_dat),
      .i_pop      (w_pop),
      .o_head     (w_head),
      .o_full     (w_fifo_full),
      .o_empty    (w_fifo_empty)
   );

   // WB data select: loads take memory data, stores carry nothing, everything else the ALU result.
   always_comb begin
      w_pipe_dat = i_pipe_alu_data;
      if (i_pipe_is_memRead) begin
         w_pipe_dat = i_pipe_mem_data;
      end else if (i_pipe_is_memWrite) begin
         w_pipe_dat = '0;
      end
   end

   // Write port mux: pipeline, else queue head, else (optionally) bypassed LU result.
   always_comb begin
      o_rf_we    = 1'b0;
      o_rf_rd    = REG_ZERO;
      o_rf_wdata = '0;
      if (!i_rst) begin
         if (w_pipe_wr) begin
            o_rf_we    = 1'b1;
            o_rf_rd    = i_pipe_rd;
            o_rf_wdata = w_pipe_dat;
         end else if (!w_fifo_empty) begin
            o_rf_we    = 1'b1;
            o_rf_rd    = w_head.rd;
            o_rf_wdata = w_head.data;
         end else if (w_bypass) begin
            o_rf_we    = 1'b1;
            o_rf_rd    = i_lu_rd;
            o_rf_wdata = i_lu_data;
         end
      end
   end

   // Starvation count: blocked cycles with work queued, saturating at the limit.
   always_comb begin
      w_cnt_nxt = r_starve_cnt;
      if (w_pop || w_fifo_empty) begin
         w_cnt_nxt = '0;
      end else if (r_starve_cnt != CW'(STARVE_LIMIT)) begin
         w_cnt_nxt = r_starve_cnt + 1'b1;
      end
   end

   // Stall request rises the cycle after the limit is hit and falls the cycle after a pop.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_starve_cnt <= '0;
         r_stall      <= 1'b0;
      end else begin
         r_starve_cnt <= w_cnt_nxt;
         if (w_pop) begin
            r_stall <= 1'b0;
         end else if (w_cnt_nxt == CW'(STARVE_LIMIT)) begin
            r_stall <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: pipeline priority, LU queueing, full, starvation, reset.
// Inputs change 1ns after the rising edge; combinational outputs are sampled 1ns later.
// Define WB_LU_BYPASS_EN to switch the bypass scenario's expectations.
module tb_wb_port_arbiter;
   logic        clk;
   logic        rst;
   logic        pipe_valid, pipe_regWrite, pipe_is_memRead, pipe_is_memWrite;
   logic [4:0]  pipe_rd;
   logic [31:0] pipe_alu_data, pipe_mem_data;
   logic        lu_valid;
   logic [4:0]  lu_rd;
   logic [31:0] lu_data;
   logic        lu_ready, rf_we, stall_req;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wdata;

   int total = 0;
   int bad   = 0;

   wb_port_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
      .i_clk              (clk),
      .i_rst              (rst),
      .i_pipe_valid       (pipe_valid),
      .i_pipe_regWrite    (pipe_regWrite),
      .i_pipe_is_memRead  (pipe_is_memRead),
      .i_pipe_is_memWrite (pipe_is_memWrite),
      .i_pipe_rd          (pipe_rd),
      .i_pipe_alu_data    (pipe_alu_data),
      .i_pipe_mem_data    (pipe_mem_data),
      .i_lu_valid         (lu_valid),
      .i_lu_rd            (lu_rd),
      .i_lu_data          (lu_data),
      .o_lu_ready         (lu_ready),
      .o_rf_we            (rf_we),
      .o_rf_rd            (rf_rd),
      .o_rf_wdata         (rf_wdata),
      .o_stall_req        (stall_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv_pipe(input logic v, input logic rw, input logic mr, input logic mw,
                           input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] mem);
      pipe_valid = v; pipe_regWrite = rw; pipe_is_memRead = mr; pipe_is_memWrite = mw;
      pipe_rd = rd; pipe_alu_data = alu; pipe_mem_data = mem;
   endtask

   task automatic drv_lu(input logic v, input logic [4:0] rd, input logic [31:0] d);
      lu_valid = v; lu_rd = rd; lu_data = d;
   endtask

   task automatic pipe_busy();
      drv_pipe(1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 32'h33, 32'h0);
   endtask

   task automatic pipe_idle();
      drv_pipe(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drv_pipe(1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 32'h1, 32'hDEADBEEF);
      drv_lu(1'b1, 5'd6, 32'h66);
      tick(); tick();
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", rf_we); end
      total++; if (rf_rd !== 5'd0) begin bad++; $display("FAIL reset_rd got=%0d exp=0", rf_rd); end
      total++; if (rf_wdata !== 32'd0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", rf_wdata); end
      total++; if (lu_ready !== 1'b0) begin bad++; $display("FAIL reset_lu_ready got=%b exp=0", lu_ready); end
      total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall_req); end
      drv_lu(1'b0, 5'd0, 32'h0);
      pipe_idle();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_load_select();
      drv_pipe(1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 32'h1111, 32'hDEADBEEF);
      #1;
      total++; if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
         bad++; $display("FAIL load we=%b rd=%0d data=%h exp 1/5/deadbeef", rf_we, rf_rd, rf_wdata); end
      tick();
      drv_pipe(1'b1, 1'b1, 1'b0, 1'b0, 5'd6, 32'h55, 32'hDEADBEEF);
      #1;
      total++; if (rf_we !== 1'b1 || rf_rd !== 5'd6 || rf_wdata !== 32'h55) begin
         bad++; $display("FAIL alu we=%b rd=%0d data=%h exp 1/6/55", rf_we, rf_rd, rf_wdata); end
      tick();
      drv_pipe(1'b1, 1'b0, 1'b0, 1'b0, 5'd6, 32'h55, 32'h0);
      #1;
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL no_regwrite we=%b exp=0", rf_we); end
      tick();
      drv_pipe(1'b0, 1'b1, 1'b0, 1'b0, 5'd6, 32'h55, 32'h0);
      #1;
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL not_valid we=%b exp=0", rf_we); end
      tick();
      pipe_idle();
   endtask

   task automatic test_lu_queue();
      pipe_busy(); drv_lu(1'b1, 5'd7, 32'h12);
      #1;
      total++; if (lu_ready !== 1'b1 || rf_we !== 1'b1 || rf_rd !== 5'd3) begin
         bad++; $display("FAIL luq_c0 ready=%b we=%b rd=%0d exp 1/1/3", lu_ready, rf_we, rf_rd); end
      tick();
      drv_lu(1'b0, 5'd0, 32'h0);
      for (int i = 1; i < 3; i++) begin
         #1;
         total++; if (rf_we !== 1'b1 || rf_rd !== 5'd3 || rf_wdata !== 32'h33) begin
            bad++; $display("FAIL luq_pipe%0d we=%b rd=%0d data=%h exp 1/3/33", i, rf_we, rf_rd, rf_wdata); end
         tick();
      end
      pipe_idle(); drv_lu(1'b1, 5'd8, 32'h88);
      #1;
      total++; if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_wdata !== 32'h12 || lu_ready !== 1'b1) begin
         bad++; $display("FAIL luq_drain7 we=%b rd=%0d data=%h ready=%b exp 1/7/12/1", rf_we, rf_rd, rf_wdata, lu_ready); end
      tick();
      drv_lu(1'b0, 5'd0, 32'h0);
      #1;
      total++; if (rf_we !== 1'b1 || rf_rd !== 5'd8 || rf_wdata !== 32'h88) begin
         bad++; $display("FAIL luq_drain8 we=%b rd=%0d data=%h exp 1/8/88", rf_we, rf_rd, rf_wdata); end
      tick();
      #1;
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL luq_empty we=%b exp=0", rf_we); end
      tick();
   endtask

   task automatic test_full();
      pipe_busy();
      for (int i = 0; i < 4; i++) begin
         drv_lu(1'b1, 5'(10 + i), 32'hA0 + 32'(i));
         #1;
         total++; if (lu_ready !== 1'b1) begin bad++; $display("FAIL full_push%0d ready=%b exp=1", i, lu_ready); end
         tick();
      end
      drv_lu(1'b1, 5'd14, 32'hA4);
      #1;
      total++; if (lu_ready !== 1'b0 || rf_rd !== 5'd3) begin
         bad++; $display("FAIL full_5th ready=%b rd=%0d exp 0/3", lu_ready, rf_rd); end
      tick();
      #1;
      total++; if (lu_ready !== 1'b0 || stall_req !== 1'b0) begin
         bad++; $display("FAIL full_held ready=%b stall=%b exp 0/0", lu_ready, stall_req); end
      tick();
      pipe_idle();
      #1;
      total++; if (rf_we !== 1'b1 || rf_rd !== 5'd10 || rf_wdata !== 32'hA0 || lu_ready !== 1'b0) begin
         bad++; $display("FAIL full_pop we=%b rd=%0d data=%h ready=%b exp 1/10/a0/0", rf_we, rf_rd, rf_wdata, lu_ready); end
      tick();
      pipe_busy();
      #1;
      total++; if (lu_ready !== 1'b1) begin bad++; $display("FAIL full_freed ready=%b exp=1", lu_ready); end
      tick();
      drv_lu(1'b0, 5'd0, 32'h0); pipe_idle();
      for (int i = 1; i < 5; i++) begin
         #1;
         total++; if (rf_we !== 1'b1 || rf_rd !== 5'(10 + i) || rf_wdata !== 32'hA0 + 32'(i)) begin
            bad++; $display("FAIL full_drain%0d we=%b rd=%0d data=%h exp rd=%0d", i, rf_we, rf_rd, rf_wdata, 10 + i); end
         tick();
      end
      #1;
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL full_empty we=%b exp=0", rf_we); end
      tick();
   endtask

   task automatic test_starve();
      pipe_busy(); drv_lu(1'b1, 5'd20, 32'h200);
      tick();
      drv_lu(1'b0, 5'd0, 32'h0);
      for (int i = 1; i <= 8; i++) begin
         #1;
         total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL starve_c%0d stall=%b exp=0", i, stall_req); end
         tick();
      end
      #1;
      total++; if (stall_req !== 1'b1) begin bad++; $display("FAIL starve_c9 stall=%b exp=1", stall_req); end
      tick();
      pipe_idle();
      #1;
      total++; if (stall_req !== 1'b1 || rf_we !== 1'b1 || rf_rd !== 5'd20 || rf_wdata !== 32'h200) begin
         bad++; $display("FAIL starve_pop stall=%b we=%b rd=%0d data=%h exp 1/1/20/200", stall_req, rf_we, rf_rd, rf_wdata); end
      tick();
      #1;
      total++; if (stall_req !== 1'b0 || rf_we !== 1'b0) begin
         bad++; $display("FAIL starve_release stall=%b we=%b exp 0/0", stall_req, rf_we); end
      tick();
   endtask

   task automatic test_store_rd0();
      pipe_busy(); drv_lu(1'b1, 5'd4, 32'h44);
      tick();
      drv_lu(1'b0, 5'd0, 32'h0);
      drv_pipe(1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 32'h99, 32'h0);
      #1;
      total++; if (rf_we !== 1'b1 || rf_rd !== 5'd4 || rf_wdata !== 32'h44) begin
         bad++; $display("FAIL store_pop we=%b rd=%0d data=%h exp 1/4/44", rf_we, rf_rd, rf_wdata); end
      tick();
      pipe_busy(); drv_lu(1'b1, 5'd4, 32'h45);
      tick();
      drv_lu(1'b0, 5'd0, 32'h0);
      drv_pipe(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h77, 32'h0);
      #1;
      total++; if (rf_we !== 1'b1 || rf_rd !== 5'd4 || rf_wdata !== 32'h45) begin
         bad++; $display("FAIL rd0_pop we=%b rd=%0d data=%h exp 1/4/45", rf_we, rf_rd, rf_wdata); end
      tick();
      pipe_idle(); drv_lu(1'b1, 5'd0, 32'h99);
      #1;
      total++; if (lu_ready !== 1'b1 || rf_we !== 1'b0) begin
         bad++; $display("FAIL lu_rd0_offer ready=%b we=%b exp 1/0", lu_ready, rf_we); end
      tick();
      drv_lu(1'b0, 5'd0, 32'h0);
      #1;
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL lu_rd0_never we=%b exp=0", rf_we); end
      tick();
   endtask

   task automatic test_reset_mid();
      pipe_busy();
      for (int i = 0; i < 3; i++) begin
         drv_lu(1'b1, 5'(21 + i), 32'h300 + 32'(i));
         tick();
      end
      drv_lu(1'b0, 5'd0, 32'h0); pipe_idle();
      rst = 1'b1;
      #1;
      total++; if (rf_we !== 1'b0 || lu_ready !== 1'b0) begin
         bad++; $display("FAIL rstmid_held we=%b ready=%b exp 0/0", rf_we, lu_ready); end
      tick();
      rst = 1'b0;
      #1;
      total++; if (rf_we !== 1'b0 || stall_req !== 1'b0 || lu_ready !== 1'b1) begin
         bad++; $display("FAIL rstmid_after we=%b stall=%b ready=%b exp 0/0/1", rf_we, stall_req, lu_ready); end
      tick();
      #1;
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rstmid_empty we=%b exp=0", rf_we); end
      tick();
   endtask

   task automatic test_bypass();
      pipe_idle(); drv_lu(1'b1, 5'd2, 32'h22);
      #1;
`ifdef WB_LU_BYPASS_EN
      total++; if (rf_we !== 1'b1 || rf_rd !== 5'd2 || rf_wdata !== 32'h22) begin
         bad++; $display("FAIL bypass_same we=%b rd=%0d data=%h exp 1/2/22", rf_we, rf_rd, rf_wdata); end
`else
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL nobypass_same we=%b exp=0", rf_we); end
`endif
      tick();
      drv_lu(1'b0, 5'd0, 32'h0);
      #1;
`ifdef WB_LU_BYPASS_EN
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL bypass_next we=%b exp=0", rf_we); end
`else
      total++; if (rf_we !== 1'b1 || rf_rd !== 5'd2 || rf_wdata !== 32'h22) begin
         bad++; $display("FAIL nobypass_next we=%b rd=%0d data=%h exp 1/2/22", rf_we, rf_rd, rf_wdata); end
`endif
      tick();
      #1;
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL bypass_idle we=%b exp=0", rf_we); end
      tick();
   endtask

   initial begin
      rst = 1'b1;
      pipe_idle();
      drv_lu(1'b0, 5'd0, 32'h0);
      #1;
      test_reset();
      test_load_select();
      test_lu_queue();
      test_full();
      test_starve();
      test_store_rd0();
      test_reset_mid();
      test_bypass();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
